// File: rtl/kbd_fifo.sv
// Keyboard scan-code FIFO: a one-entry stage feeds a show-ahead FIFO that has a sticky overflow flag.
// Define KBD_ASCII_EN to translate set-2 make codes to ASCII in the stage. Unmapped codes become 0x00 and are dropped.
`timescale 1ns/1ps
module kbd_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk_50mhz,
  input  logic          reset,
  input  logic [7:0]    key_in,
  input  logic          rd_en,
  input  logic          clr_ovf,
  output logic [7:0]    data_out,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count,
  output logic          overflow
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic          stg_valid_q, stg_valid_d;
  logic [7:0]    stg_data_q, stg_data_d;
  logic [7:0]    xlat;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    mem_q [DEPTH];
  logic          wr_req, pop, wr_acc, drop;

  always_comb begin
`ifdef KBD_ASCII_EN
    xlat = 8'h00;
    case (key_in)
      8'h1C: xlat = 8'h61;  8'h32: xlat = 8'h62;  8'h21: xlat = 8'h63;
      8'h23: xlat = 8'h64;  8'h24: xlat = 8'h65;  8'h2B: xlat = 8'h66;
      8'h34: xlat = 8'h67;  8'h33: xlat = 8'h68;  8'h43: xlat = 8'h69;
      8'h3B: xlat = 8'h6A;  8'h42: xlat = 8'h6B;  8'h4B: xlat = 8'h6C;
      8'h3A: xlat = 8'h6D;  8'h31: xlat = 8'h6E;  8'h44: xlat = 8'h6F;
      8'h4D: xlat = 8'h70;  8'h15: xlat = 8'h71;  8'h2D: xlat = 8'h72;
      8'h1B: xlat = 8'h73;  8'h2C: xlat = 8'h74;  8'h3C: xlat = 8'h75;
      8'h2A: xlat = 8'h76;  8'h1D: xlat = 8'h77;  8'h22: xlat = 8'h78;
      8'h35: xlat = 8'h79;  8'h1A: xlat = 8'h7A;
      8'h45: xlat = 8'h30;  8'h16: xlat = 8'h31;  8'h1E: xlat = 8'h32;
      8'h26: xlat = 8'h33;  8'h25: xlat = 8'h34;  8'h2E: xlat = 8'h35;
      8'h36: xlat = 8'h36;  8'h3D: xlat = 8'h37;  8'h3E: xlat = 8'h38;
      8'h46: xlat = 8'h39;
      8'h29: xlat = 8'h20;  8'h5A: xlat = 8'h0D;  8'h66: xlat = 8'h08;
      default: xlat = 8'h00;
    endcase
`else
    xlat = key_in;
`endif
  end

  always_comb begin
    stg_valid_d = (key_in != 8'h00);
    stg_data_d  = xlat;

    wr_req = stg_valid_q && (stg_data_q != 8'h00);
    pop    = rd_en && (count_q != '0);
    // When the FIFO is full, a same-cycle pop frees the slot for the write.
    wr_acc = wr_req && ((count_q != FULL_CNT) || pop);
    drop   = wr_req && !wr_acc;

    wr_ptr_d = wr_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop    ? rd_ptr_q + 1'b1 : rd_ptr_q;

    count_d = count_q;
    case ({wr_acc, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    overflow_d = overflow_q;
    if (drop)         overflow_d = 1'b1;
    else if (clr_ovf) overflow_d = 1'b0;
  end

  always_ff @(posedge clk_50mhz or negedge reset) begin
    if (!reset) begin
      stg_valid_q <= 1'b0;
      stg_data_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
    end else begin
      stg_valid_q <= stg_valid_d;
      stg_data_q  <= stg_data_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
    end
  end

  // Storage has no reset: an entry is only visible while count covers it.
  always_ff @(posedge clk_50mhz) begin
    if (wr_acc) mem_q[wr_ptr_q] <= stg_data_q;
  end

  assign count    = count_q;
  assign empty    = (count_q == '0);
  assign full     = (count_q == FULL_CNT);
  assign overflow = overflow_q;
  assign data_out = empty ? 8'h00 : mem_q[rd_ptr_q];

endmodule

// File: tb/tb_kbd_fifo.sv
// Randomized self-checking bench for kbd_fifo. Its queue-based reference model covers both the raw build and the KBD_ASCII_EN build.
`timescale 1ns/1ps
module tb_kbd_fifo;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int VW    = 8 + AW + 1 + 3;

`ifdef KBD_ASCII_EN
  localparam logic [7:0] LETTERS [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
    8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B,
    8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  localparam logic [7:0] DIGITS [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36,
    8'h3D, 8'h3E, 8'h46};
  localparam logic [7:0] EXP_A = 8'h61, EXP_ONE = 8'h31, EXP_SP = 8'h20;
  localparam logic       EXP_UNM_EMPTY = 1'b1;
`else
  localparam logic [7:0] EXP_A = 8'h1C, EXP_ONE = 8'h16, EXP_SP = 8'h29;
  localparam logic       EXP_UNM_EMPTY = 1'b0;
`endif
  localparam logic [7:0] POOL [10] = '{8'h1C, 8'h32, 8'h21, 8'h16, 8'h1E, 8'h29, 8'h5A,
    8'h66, 8'h45, 8'h3D};

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [7:0]    key_in = '0;
  logic          rd_en = 1'b0, clr_ovf = 1'b0;
  logic [7:0]    data_out;
  logic          empty, full, overflow;
  logic [AW:0]   count;

  int unsigned vectors = 0, miscompares = 0;

  logic [7:0] q[$];
  logic       m_stg_v = 1'b0;
  logic [7:0] m_stg = '0;
  logic       m_ovf = 1'b0;

  always #10 clk = ~clk;

  kbd_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk_50mhz(clk), .reset(reset), .key_in(key_in), .rd_en(rd_en), .clr_ovf(clr_ovf),
    .data_out(data_out), .empty(empty), .full(full), .count(count), .overflow(overflow)
  );

  function automatic logic [7:0] ref_xlat(input logic [7:0] k);
`ifdef KBD_ASCII_EN
    for (int i = 0; i < 26; i++) if (k == LETTERS[i]) return 8'h61 + 8'(i);
    for (int i = 0; i < 10; i++) if (k == DIGITS[i]) return 8'h30 + 8'(i);
    if (k == 8'h29) return 8'h20;
    if (k == 8'h5A) return 8'h0D;
    if (k == 8'h66) return 8'h08;
    return 8'h00;
`else
    return k;
`endif
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    logic [7:0] head;
    head = (q.size() > 0) ? q[0] : 8'h00;
    return {head, (AW+1)'(q.size()), q.size() == 0, q.size() == DEPTH, m_ovf};
  endfunction

  // Applies one clock edge to the DUT and advances the model. The model works on the pre-edge inputs.
  task automatic cycle(input logic [7:0] k, input logic rd, input logic clr);
    bit do_pop, drop;
    key_in = k; rd_en = rd; clr_ovf = clr;
    @(posedge clk);
    do_pop = rd && (q.size() > 0);
    drop   = 1'b0;
    if (do_pop) void'(q.pop_front());
    if (m_stg_v && m_stg != 8'h00) begin
      if (q.size() < DEPTH) q.push_back(m_stg);
      else drop = 1'b1;
    end
    if (drop) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    m_stg_v = (k != 8'h00);
    m_stg   = ref_xlat(k);
    #1;
    key_in = '0; rd_en = 1'b0; clr_ovf = 1'b0;
  endtask

  task automatic assert_reset();
    reset = 1'b0;
    q.delete(); m_stg_v = 1'b0; m_stg = '0; m_ovf = 1'b0;
  endtask

  task automatic release_reset();
    @(negedge clk);
    key_in = '0;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    assert_reset();
    key_in = 8'h1C;
    #35;
    vectors++;
    if ({data_out, count, empty, full, overflow} !== exp_vec()) begin
      miscompares++;
      $display("FAIL reset_state: got %h want %h", {data_out, count, empty, full, overflow}, exp_vec());
    end
    release_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(8'h00, 1'b0, 1'b0);
      vectors++;
      if ({data_out, count, empty, full, overflow} !== exp_vec()) begin
        miscompares++;
        $display("FAIL reset_release[%0d]: got %h want %h", i, {data_out, count, empty, full, overflow}, exp_vec());
      end
    end
  endtask

  task automatic test_first_key();
    cycle(8'h1C, 1'b0, 1'b0);
    vectors++;
    if (empty !== 1'b1) begin
      miscompares++;
      $display("FAIL first_key_latency: empty got %b want 1", empty);
    end
    cycle(8'h00, 1'b0, 1'b0);
    vectors++;
    if (empty !== 1'b0 || data_out !== EXP_A || count !== 5'd1) begin
      miscompares++;
      $display("FAIL first_key: empty/data/count got %b/%h/%0d want 0/%h/1", empty, data_out, count, EXP_A);
    end
    vectors++;
    if ({data_out, count, empty, full, overflow} !== exp_vec()) begin
      miscompares++;
      $display("FAIL first_key_model: got %h want %h", {data_out, count, empty, full, overflow}, exp_vec());
    end
  endtask

  task automatic test_overflow();
    assert_reset(); #5; release_reset();
    for (int i = 0; i < 18; i++) begin
      cycle((i < 16) ? 8'h16 : (i == 16 ? 8'h1E : 8'h00), 1'b0, 1'b0);
      vectors++;
      if ({data_out, count, empty, full, overflow} !== exp_vec()) begin
        miscompares++;
        $display("FAIL fill[%0d]: got %h want %h", i, {data_out, count, empty, full, overflow}, exp_vec());
      end
    end
    vectors++;
    if (full !== 1'b1 || count !== 5'd16 || overflow !== 1'b1 || data_out !== EXP_ONE) begin
      miscompares++;
      $display("FAIL overflow_set: full/count/ovf/head got %b/%0d/%b/%h want 1/16/1/%h", full, count, overflow, data_out, EXP_ONE);
    end
    cycle(8'h00, 1'b0, 1'b1);
    vectors++;
    if (overflow !== 1'b0 || count !== 5'd16) begin
      miscompares++;
      $display("FAIL clr_ovf: ovf/count got %b/%0d want 0/16", overflow, count);
    end
  endtask

  task automatic test_full_write_pop();
    cycle(8'h29, 1'b0, 1'b0);
    cycle(8'h00, 1'b1, 1'b0);
    vectors++;
    if (count !== 5'd16 || overflow !== 1'b0 || full !== 1'b1) begin
      miscompares++;
      $display("FAIL full_write_pop: count/ovf/full got %0d/%b/%b want 16/0/1", count, overflow, full);
    end
    for (int i = 0; i < 16; i++) begin
      if (i == 15) begin
        vectors++;
        if (data_out !== EXP_SP) begin
          miscompares++;
          $display("FAIL last_entry: got %h want %h", data_out, EXP_SP);
        end
      end
      cycle(8'h00, 1'b1, 1'b0);
      vectors++;
      if ({data_out, count, empty, full, overflow} !== exp_vec()) begin
        miscompares++;
        $display("FAIL drain[%0d]: got %h want %h", i, {data_out, count, empty, full, overflow}, exp_vec());
      end
    end
  endtask

  task automatic test_unmapped();
    assert_reset(); #5; release_reset();
    cycle(8'h76, 1'b0, 1'b0);
    cycle(8'h00, 1'b0, 1'b0);
    vectors++;
    if (empty !== EXP_UNM_EMPTY || overflow !== 1'b0 || (!EXP_UNM_EMPTY && data_out !== 8'h76)) begin
      miscompares++;
      $display("FAIL unmapped: empty/ovf/data got %b/%b/%h want %b/0/%h", empty, overflow, data_out, EXP_UNM_EMPTY, EXP_UNM_EMPTY ? 8'h00 : 8'h76);
    end
  endtask

  task automatic test_empty_read_and_wrap();
    assert_reset(); #5; release_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(8'h00, 1'b1, 1'b0);
      vectors++;
      if (count !== '0 || empty !== 1'b1) begin
        miscompares++;
        $display("FAIL empty_read[%0d]: count/empty got %0d/%b want 0/1", i, count, empty);
      end
    end
    for (int i = 0; i < 24; i++) begin
      cycle((i < 20) ? POOL[$urandom_range(0, 9)] : 8'h00, (i > 0), 1'b0);
      vectors++;
      if ({data_out, count, empty, full, overflow} !== exp_vec()) begin
        miscompares++;
        $display("FAIL wrap[%0d]: got %h want %h", i, {data_out, count, empty, full, overflow}, exp_vec());
      end
    end
  endtask

  task automatic test_reset_midstream();
    assert_reset(); #5; release_reset();
    cycle(8'h1C, 1'b0, 1'b0);
    cycle(8'h32, 1'b0, 1'b0);
    assert_reset();
    #1;
    vectors++;
    if (empty !== 1'b1 || count !== '0 || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid: empty/count/ovf got %b/%0d/%b want 1/0/0", empty, count, overflow);
    end
    release_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(8'h00, 1'b0, 1'b0);
      vectors++;
      if (empty !== 1'b1 || count !== '0) begin
        miscompares++;
        $display("FAIL reset_mid_after[%0d]: empty/count got %b/%0d want 1/0", i, empty, count);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] k;
    logic rd;
    for (int i = 0; i < 450; i++) begin
      k  = ($urandom_range(0, 3) == 0) ? 8'h00 :
           ($urandom_range(0, 1) == 0) ? POOL[$urandom_range(0, 9)] : 8'($urandom_range(1, 255));
      rd = (i < 150) ? ($urandom_range(0, 7) == 0) :
           (i < 300) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 7) != 0);
      cycle(k, rd, $urandom_range(0, 15) == 0);
      vectors++;
      if ({data_out, count, empty, full, overflow} !== exp_vec()) begin
        miscompares++;
        $display("FAIL random[%0d]: got %h want %h", i, {data_out, count, empty, full, overflow}, exp_vec());
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_first_key();
    test_overflow();
    test_full_write_pop();
    test_unmapped();
    test_empty_read_and_wrap();
    test_reset_midstream();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
